// File: rtl/aes_pkg.sv
// Shared AES constants: key-schedule sizing, key-expansion FSM state codes and the forward S-box.
package aes_pkg;

  localparam int AES_NK = 8;
  localparam int AES_NR = 14;
  localparam int WORD_W = 32;
  localparam int RK_W   = 128;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;
  localparam logic [1:0] ST_GEN  = 2'd3;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: forward S-box applied independently to each byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] w,
  output logic [WORD_W-1:0] s
);

  assign s = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};

endmodule

// File: rtl/aes256_key_expand.sv
// Sequential AES-256 key schedule: one expanded word per cycle, round keys streamed with an index tag.
// state | meaning
// IDLE  | waiting for start; window holds the last key
// EMIT  | two cycles presenting rk0 and rk1 straight from the loaded key
// REQ   | rcon ROM read for group grp; data is ready for the next GEN
// GEN   | one new word per cycle; a round key completes every fourth word
module aes256_key_expand
  import aes_pkg::*;
#(
  parameter int NK = AES_NK,
  parameter int NR = AES_NR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [255:0]    key,
  output logic            rcon_rd,
  output logic [3:0]      rcon_addr,
  input  logic [31:0]     rcon,
  output logic            busy,
  output logic            rk_valid,
  output logic [3:0]      rk_index,
  output logic [RK_W-1:0] round_key,
  output logic            done
);

  localparam int LAST_W = 4 * (NR + 1) - 1;

  logic [1:0]        state;
  logic [WORD_W-1:0] win [NK];
  logic [5:0]        wi;
  logic [2:0]        grp;
  logic              emit_hi;
  logic [WORD_W-1:0] t_prev, sw_in, sw_out, w_new;
  logic              rot_step, sub_step;

  assign t_prev   = win[NK-1];
  assign rot_step = (wi[2:0] == 3'd0);
  assign sub_step = (wi[2:0] == 3'd4);

  // One S-box instance serves both the RotWord and the plain SubWord steps.
  assign sw_in = rot_step ? {t_prev[23:0], t_prev[31:24]} : t_prev;

  aes_sub_word u_sub (.w(sw_in), .s(sw_out));

  always_comb begin
    w_new = win[0] ^ t_prev;
    if (rot_step)
      w_new = win[0] ^ sw_out ^ rcon;
    else if (sub_step)
      w_new = win[0] ^ sw_out;
  end

  assign busy      = (state != ST_IDLE);
  assign rcon_rd   = (state == ST_REQ);
  assign rcon_addr = {1'b0, grp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wi        <= '0;
      grp       <= '0;
      emit_hi   <= 1'b0;
      rk_valid  <= 1'b0;
      done      <= 1'b0;
      rk_index  <= '0;
      round_key <= '0;
      for (int j = 0; j < NK; j++) win[j] <= '0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            for (int j = 0; j < NK; j++) win[j] <= key[255-32*j -: 32];
            wi      <= 6'd8;
            grp     <= 3'd1;
            emit_hi <= 1'b0;
            state   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          rk_valid <= 1'b1;
          emit_hi  <= 1'b1;
          if (!emit_hi) begin
            rk_index  <= 4'd0;
            round_key <= {win[0], win[1], win[2], win[3]};
          end else begin
            rk_index  <= 4'd1;
            round_key <= {win[4], win[5], win[6], win[7]};
            state     <= ST_REQ;
          end
        end
        ST_REQ: state <= ST_GEN;
        ST_GEN: begin
          for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
          win[NK-1] <= w_new;
          wi        <= wi + 6'd1;
          if (wi[1:0] == 2'd3) begin
            rk_valid  <= 1'b1;
            rk_index  <= wi[5:2];
            round_key <= {win[NK-3], win[NK-2], win[NK-1], w_new};
          end
          if (wi == 6'(LAST_W)) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (wi[2:0] == 3'(NK - 1)) begin
            grp   <= grp + 3'd1;
            state <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed and random bench for aes256_key_expand with a registered rcon ROM model and an independent reference key schedule.
module tb_aes256_key_expand;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [255:0] key;
  logic         rcon_rd;
  logic [3:0]   rcon_addr;
  logic [31:0]  rcon;
  logic         busy, rk_valid, done;
  logic [3:0]   rk_index;
  logic [127:0] round_key;

  always #5 clk = ~clk;

  aes256_key_expand dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .rcon_rd(rcon_rd), .rcon_addr(rcon_addr), .rcon(rcon),
    .busy(busy), .rk_valid(rk_valid), .rk_index(rk_index),
    .round_key(round_key), .done(done)
  );

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rc_of(input logic [3:0] a);
    case (a)
      4'd1: rc_of = 8'h01;
      4'd2: rc_of = 8'h02;
      4'd3: rc_of = 8'h04;
      4'd4: rc_of = 8'h08;
      4'd5: rc_of = 8'h10;
      4'd6: rc_of = 8'h20;
      4'd7: rc_of = 8'h40;
      default: rc_of = 8'h00;
    endcase
  endfunction

  logic rom_bad = 1'b0;
  always @(posedge clk or posedge rst)
    if (rst) rcon <= '0;
    else if (rcon_rd)
      rcon <= {rc_of(rcon_addr) ^ ((rom_bad && rcon_addr == 4'd1) ? 8'h5a : 8'h00), 24'h0};

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];
  int           got_idx [15];
  int           got_t [15];
  int           rd_addr [8];
  int           rd_t [8];
  int           n_rk, n_rd, busy_n, done_t, e0;
  int           npass = 0, nfail = 0, ntot = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic ref_expand(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int j = 0; j < 8; j++) w[j] = k[255-32*j -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%032h expected=%032h", tag, obs, expv);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int expv);
    ntot++;
    assert (obs == expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chki({tag, "_busy"}, int'(busy), 0);
    chki({tag, "_rk_valid"}, int'(rk_valid), 0);
    chki({tag, "_done"}, int'(done), 0);
    chki({tag, "_rcon_rd"}, int'(rcon_rd), 0);
    chki({tag, "_rk_index"}, int'(rk_index), 0);
    chki({tag, "_rcon_addr"}, int'(rcon_addr), 0);
    chk({tag, "_round_key"}, round_key, 128'h0);
  endtask

  // Caller must be at a falling edge; start is sampled on the next rising edge (E0).
  task automatic run(input logic [255:0] k, input bit inj);
    int rel;
    bit fin;
    key = k; start = 1'b1; e0 = cyc + 1;
    n_rk = 0; n_rd = 0; busy_n = 0; done_t = -1; fin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 80 && !fin; n++) begin
      rel = cyc - e0;
      if (busy) busy_n++;
      if (rk_valid && n_rk < 15) begin
        got_rk[n_rk] = round_key; got_idx[n_rk] = int'(rk_index); got_t[n_rk] = rel;
      end
      if (rk_valid) n_rk++;
      if (rcon_rd && n_rd < 8) begin
        rd_addr[n_rd] = int'(rcon_addr); rd_t[n_rd] = rel;
      end
      if (rcon_rd) n_rd++;
      if (done) begin done_t = rel; fin = 1'b1; end
      start = inj && (rel == 9 || rel == 29);
      if (!fin) @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int et;
    chki({tag, "_n_rk"}, n_rk, 15);
    chki({tag, "_busy_cycles"}, busy_n, 61);
    chki({tag, "_done_time"}, done_t, 61);
    for (int r = 0; r < 15; r++) begin
      et = (r < 2) ? r + 1 : (4*r + 3) / 8 + 4*r - 2;
      chk($sformatf("%s_rk%0d", tag, r), got_rk[r], exp_rk[r]);
      chki($sformatf("%s_idx%0d", tag, r), got_idx[r], r);
      chki($sformatf("%s_time%0d", tag, r), got_t[r], et);
    end
  endtask

  initial begin
    logic [7:0]   inv;
    logic [255:0] kr;
    int           stray;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    rst = 1'b1; start = 1'b0; key = '0;
    repeat (3) @(negedge clk);
    chk_idle_zero("por");
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 A.3 key, with start re-asserted while busy at E10 and E30
    ref_expand(KEY_A3);
    run(KEY_A3, 1'b1);
    chk("a3_rk0_const", got_rk[0], 128'h603deb1015ca71be2b73aef0857d7781);
    chk("a3_rk1_const", got_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("a3_rk2_const", got_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("a3_rk14_const", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    check_all("a3");
    chki("a3_n_rcon_rd", n_rd, 7);
    for (int j = 0; j < 7; j++) begin
      chki($sformatf("a3_rcon_addr%0d", j), rd_addr[j], j + 1);
      chki($sformatf("a3_rcon_time%0d", j), rd_t[j], 2 + 9*j);
    end

    // back-to-back: start in the cycle right after done, all-zero key
    ref_expand('0);
    run('0, 1'b0);
    chk("zero_rk0", got_rk[0], 128'h0);
    chk("zero_rk1", got_rk[1], 128'h0);
    chk("zero_rk2", got_rk[2], 128'h62636363626363636263636362636363);
    check_all("zero");

    // reset mid-run, then a fresh run
    @(negedge clk);
    key = KEY_A3; start = 1'b1; e0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc - e0 < 19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_zero("midrst");
    rst = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (rk_valid || busy || done) stray++;
    end
    chki("midrst_stray_outputs", stray, 0);
    ref_expand(KEY_A3);
    run(KEY_A3, 1'b0);
    chk("after_rst_rk14_const", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    check_all("after_rst");

    // corrupted rcon at group 1 must reach rk2
    @(negedge clk);
    rom_bad = 1'b1;
    run(KEY_A3, 1'b0);
    rom_bad = 1'b0;
    ntot++;
    assert (got_rk[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) npass++;
    else begin
      nfail++;
      $error("FAIL bad_rcon_rk2 observed=%032h expected any value other than that", got_rk[2]);
    end

    for (int r = 0; r < 100; r++) begin
      kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ref_expand(kr);
      @(negedge clk);
      run(kr, 1'b0);
      check_all($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
